// File: rtl/antirrebote_botones_pkg.sv
// -----------------------------------------------------------------------------
// antirrebote_botones_pkg
// Shared definitions for the push-button debouncer:
//   - canal_state_t : per-channel FSM state encoding (2 bits)
//   - CNT_W         : width of the debounce counter
//   - RPT_W         : width of the auto-repeat counter (optional feature,
//                     enabled by ANTIRREBOTE_AUTO_REPEAT_EN)
//   - sat_inc()     : saturating increment for the debounce counter
// -----------------------------------------------------------------------------
package antirrebote_botones_pkg;

    localparam int CNT_W = 24;
    localparam int RPT_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } canal_state_t;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/antirrebote_botones_canal.sv
// -----------------------------------------------------------------------------
// antirrebote_canal
// One debounced push-button channel: 2-flop synchronizer, debounce FSM with a
// saturating counter, one-cycle raw pulse on each accepted press and the
// debounced level.  With ANTIRREBOTE_AUTO_REPEAT_EN defined, a held button
// also emits repeat pulses after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   btn    in   raw asynchronous button, high = pressed
//   pulse  out  registered one-cycle press pulse
//   level  out  debounced level (high in HELD / RELEASING)
// -----------------------------------------------------------------------------
module antirrebote_canal
    import antirrebote_botones_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse,
    output logic level
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_debounce
        $error("antirrebote_canal: DEBOUNCE_CYCLES out of range");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("antirrebote_canal: repeat parameters must be positive");
    end

    // The first high (or low) sample is taken in IDLE (or HELD), so ARMING /
    // RELEASING only need DEBOUNCE_CYCLES-1 more; the counter starts at 0.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic [1:0]       sync_q;
    logic             btn_s;
    canal_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_d;
    logic             rpt_fire;

    assign btn_s = sync_q[1];

    // State register, counter and registered pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse   <= pulse_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (btn_s) state_d = ARMING;
            ARMING:    if (!btn_s) state_d = IDLE;
                       else if (cnt_q == CNT_LAST) state_d = HELD;
            HELD:      if (!btn_s) state_d = RELEASING;
            RELEASING: if (btn_s) state_d = HELD;
                       else if (cnt_q == CNT_LAST) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // Any transition restarts the count; only the qualifying states count.
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q == ARMING || state_q == RELEASING)
            cnt_d = sat_inc(cnt_q);
        else
            cnt_d = '0;
    end

`ifdef ANTIRREBOTE_AUTO_REPEAT_EN
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;
    logic             staying_held;

    // rpt_q counts cycles spent in HELD; it is zero in the entry cycle. The
    // first fire waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    always_comb begin
        staying_held = (state_q == HELD) && (state_d == HELD);
        rpt_fire     = staying_held &&
                       (rpt_q == (rpt_first_q ? RPT_W'(REPEAT_PERIOD - 1)
                                              : RPT_W'(REPEAT_DELAY - 1)));
        rpt_d        = rpt_q + 1'b1;
        rpt_first_d  = rpt_first_q;
        if (!staying_held) begin
            rpt_d       = '0;
            rpt_first_d = 1'b0;
        end else if (rpt_fire) begin
            rpt_d       = '0;
            rpt_first_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Outputs
    always_comb begin
        pulse_d = ((state_q == ARMING) && (state_d == HELD)) || rpt_fire;
        level   = (state_q == HELD) || (state_q == RELEASING);
    end

endmodule

// File: rtl/antirrebote_botones.sv
// -----------------------------------------------------------------------------
// antirrebote_botones
// Debounces the up/down buttons feeding the duty-cycle register and turns each
// accepted press into a one-cycle increment/decrement request.  Optional
// auto-repeat is enabled by defining ANTIRREBOTE_AUTO_REPEAT_EN.
//
// Ports:
//   clk_100MHz  in   clock, rising edge
//   rst         in   synchronous active-high reset
//   btn_up      in   raw up button, high = pressed
//   btn_down    in   raw down button, high = pressed
//   en          in   pulse enable (chip select of the duty-cycle register)
//   pulse_up    out  one-cycle increment request
//   pulse_down  out  one-cycle decrement request
//   up_level    out  debounced up level
//   down_level  out  debounced down level
// -----------------------------------------------------------------------------
module antirrebote_botones
    import antirrebote_botones_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic en,
    output logic pulse_up,
    output logic pulse_down,
    output logic up_level,
    output logic down_level
);

    logic raw_up, raw_down;

    antirrebote_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_canal_up (
        .clk  (clk_100MHz),
        .rst  (rst),
        .btn  (btn_up),
        .pulse(raw_up),
        .level(up_level)
    );

    antirrebote_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_canal_down (
        .clk  (clk_100MHz),
        .rst  (rst),
        .btn  (btn_down),
        .pulse(raw_down),
        .level(down_level)
    );

    // A pulse seen while en is low is simply lost. Simultaneous up and down
    // requests cancel so the duty-cycle counter never sees both.
    always_comb begin
        pulse_up   = raw_up   & en & ~raw_down;
        pulse_down = raw_down & en & ~raw_up;
    end

endmodule

// File: tb/tb_antirrebote_botones.sv
// -----------------------------------------------------------------------------
// tb_antirrebote_botones
// Directed scenarios followed by random button/en/reset traffic. Every cycle
// the DUT is compared against a reference model that tracks, per channel,
// the synchronized sample stream, the accepted level and the run length of
// samples disagreeing with it.
// -----------------------------------------------------------------------------
module tb_antirrebote_botones;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic clk_100MHz = 1'b0;
    logic rst = 1'b1, btn_up = 1'b0, btn_down = 1'b0, en = 1'b1;
    logic pulse_up, pulse_down, up_level, down_level;

    antirrebote_botones #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk_100MHz(clk_100MHz), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .en(en), .pulse_up(pulse_up), .pulse_down(pulse_down),
        .up_level(up_level), .down_level(down_level)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int pu_cnt, pd_cnt, first_pu, first_pd;

    // reference model state, index 0 = up, 1 = down
    bit m_s1[2], m_s2[2], m_lvl[2], m_pr[2], m_held[2];
    int m_run[2], m_age[2];

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit b, smp, now_held;
        for (int c = 0; c < 2; c++) begin
            b = (c == 0) ? btn_up : btn_down;
            if (rst) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pr[c] = 0;
                m_held[c] = 0; m_run[c] = 0; m_age[c] = 0;
            end else begin
                smp = m_s2[c];
                m_pr[c] = 0;
                if (smp != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_lvl[c] = smp;
                        m_run[c] = 0;
                        m_pr[c]  = smp;
                    end
                end else begin
                    m_run[c] = 0;
                end
                now_held = m_lvl[c] && (m_run[c] == 0);
                if (now_held && m_held[c]) m_age[c]++;
                else m_age[c] = 0;
`ifdef ANTIRREBOTE_AUTO_REPEAT_EN
                if (now_held && m_held[c] && m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0)
                    m_pr[c] = 1;
`endif
                m_held[c] = now_held;
                m_s2[c] = m_s1[c];
                m_s1[c] = b;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        cyc++;
        model_edge();
        #1;
        chk("up_level",   up_level,   m_lvl[0]);
        chk("down_level", down_level, m_lvl[1]);
        chk("pulse_up",   pulse_up,   m_pr[0] & en & ~m_pr[1]);
        chk("pulse_down", pulse_down, m_pr[1] & en & ~m_pr[0]);
        if (pulse_up) begin
            pu_cnt++;
            if (first_pu < 0) first_pu = cyc;
        end
        if (pulse_down) begin
            pd_cnt++;
            if (first_pd < 0) first_pd = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_cnt();
        pu_cnt = 0; pd_cnt = 0; first_pu = -1; first_pd = -1;
    endtask

    initial begin
        int t0;
        clr_cnt();

        // reset state
        run(3);
        chk("rst_up_level", up_level, 1'b0);
        chk("rst_down_level", down_level, 1'b0);
        chk("rst_pulse_up", pulse_up, 1'b0);
        chk("rst_pulse_down", pulse_down, 1'b0);
        rst = 1'b0;
        run(5);

        // single up press
        clr_cnt(); t0 = cyc; btn_up = 1'b1;
        run(30);
        chk("s1_up_level", up_level, 1'b1);
        btn_up = 1'b0; run(15);
`ifdef ANTIRREBOTE_AUTO_REPEAT_EN
        chk_i("s1_pu_cnt", pu_cnt, 2);
`else
        chk_i("s1_pu_cnt", pu_cnt, 1);
`endif
        chk_i("s1_latency", first_pu - t0, 10);
        chk_i("s1_pd_cnt", pd_cnt, 0);

        // bouncing down press
        clr_cnt();
        for (int k = 0; k < 3; k++) begin
            btn_down = 1'b1; run(5);
            btn_down = 1'b0; run(2);
        end
        t0 = cyc; btn_down = 1'b1;
        run(15);
        btn_down = 1'b0; run(15);
        chk_i("s2_pd_cnt", pd_cnt, 1);
        chk_i("s2_latency", first_pd - t0, 10);
        chk_i("s2_pu_cnt", pu_cnt, 0);

        // simultaneous presses cancel
        clr_cnt(); btn_up = 1'b1; btn_down = 1'b1;
        run(9);
        chk("s3_up_level_early", up_level, 1'b0);
        step();
        chk("s3_up_level", up_level, 1'b1);
        chk("s3_down_level", down_level, 1'b1);
        run(5);
        btn_up = 1'b0; btn_down = 1'b0; run(15);
        chk_i("s3_pu_cnt", pu_cnt, 0);
        chk_i("s3_pd_cnt", pd_cnt, 0);

        // press accepted while en is low
        clr_cnt(); en = 1'b0; btn_up = 1'b1;
        run(12);
        en = 1'b1;
        run(8);
        chk("s4_up_level", up_level, 1'b1);
        btn_up = 1'b0; run(15);
        chk_i("s4_pu_cnt", pu_cnt, 0);

        // reset while held: treated as a fresh press
        btn_up = 1'b1; run(14);
        clr_cnt(); rst = 1'b1; step();
        chk("s5_rst_up_level", up_level, 1'b0);
        chk("s5_rst_pulse_up", pulse_up, 1'b0);
        rst = 1'b0; t0 = cyc;
        run(14);
        chk_i("s5_pu_cnt", pu_cnt, 1);
        chk_i("s5_latency", first_pu - t0, 10);
        btn_up = 1'b0; run(15);

        // long hold
        clr_cnt(); t0 = cyc; btn_up = 1'b1;
        run(60);
        btn_up = 1'b0; run(15);
`ifdef ANTIRREBOTE_AUTO_REPEAT_EN
        chk_i("s6_pu_cnt", pu_cnt, 8);
`else
        chk_i("s6_pu_cnt", pu_cnt, 1);
`endif
        chk_i("s6_first", first_pu - t0, 10);

        // random traffic
        for (int k = 0; k < 50; k++) begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1; step(); rst = 1'b0;
            end
            run($urandom_range(1, 25));
        end
        btn_up = 1'b0; btn_down = 1'b0; run(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
